merge_ni: RTL and testbench

- Parametrised N-channel pixel-stream merger with per-channel buffering.
- Successor to the fixed-size 2/4/32-input merge trees: one block serialises N parallel pixel streams onto one output stream.
- Sits between parallel compute lanes and a single downstream consumer.
- Adds per-channel FIFOs, downstream backpressure, a selectable arbitration mode, a channel tag and sticky overflow flags.

---
 rtl/merge_ni.sv | 138 +++++++++++++
 tb/tb_merge_ni.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/merge_ni.sv
// merge_ni: N-channel pixel-stream merger.
// Each input channel has its own FIFO. One output register serialises the
// FIFO heads. MODE 0 keeps a strict ch0..chN-1 interleave. MODE 1 is a
// work-conserving round-robin. Dropped pixels set sticky per-channel flags.
module merge_ni #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int MODE       = 0,
  localparam int CW        = (N > 1) ? $clog2(N) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N-1:0]            valid_in,
  input  logic [N*DATA_WIDTH-1:0] pxl_in,
  input  logic                    ready_out,
  output logic [DATA_WIDTH-1:0]   pxl_out,
  output logic                    valid_out,
  output logic [CW-1:0]           ch_out,
  output logic [N-1:0]            fifo_full,
  output logic [N-1:0]            overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [N-1:0]          fifo_empty;
  logic [N-1:0]          wr_en;
  logic [N-1:0]          rd_en;
  logic [DATA_WIDTH-1:0] head [N];

  logic [CW-1:0] arb_ptr_reg;
  logic [CW-1:0] sel;
  logic [CW-1:0] arb_ptr_next;
  logic          sel_valid;
  logic          out_free;
  logic          load;
  logic [CW:0]   idx;

  // The output register may take a new pixel when it is empty or being consumed
  assign out_free = !valid_out || ready_out;
  assign load     = out_free && sel_valid;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_ch
      logic [DATA_WIDTH-1:0] mem [DEPTH];
      logic [AW:0]           wr_ptr_reg;
      logic [AW:0]           rd_ptr_reg;
      logic                  overflow_reg;

      // Pointers carry an extra wrap bit to tell full from empty
      assign fifo_empty[gi] = (wr_ptr_reg == rd_ptr_reg);
      assign fifo_full[gi]  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                              (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
      // A full FIFO rejects the write even if it is popped this same cycle
      assign wr_en[gi]      = valid_in[gi] && !fifo_full[gi];
      assign rd_en[gi]      = load && (sel == CW'(gi));
      assign head[gi]       = mem[rd_ptr_reg[AW-1:0]];
      assign overflow[gi]   = overflow_reg;

      // Storage array: contents are never cleared, only pointers are
      always_ff @(posedge clk) begin
        if (wr_en[gi]) begin
          mem[wr_ptr_reg[AW-1:0]] <= pxl_in[gi*DATA_WIDTH +: DATA_WIDTH];
        end
      end

      // Pointer advance and sticky drop flag for this channel
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          wr_ptr_reg   <= '0;
          rd_ptr_reg   <= '0;
          overflow_reg <= 1'b0;
        end else begin
          if (wr_en[gi]) begin
            wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
          end
          if (rd_en[gi]) begin
            rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
          end
          if (valid_in[gi] && fifo_full[gi]) begin
            overflow_reg <= 1'b1;
          end
        end
      end
    end
  endgenerate

  // Channel selection: fixed pointer in ordered mode, first non-empty from the pointer otherwise
  always_comb begin
    sel       = arb_ptr_reg;
    sel_valid = 1'b0;
    idx       = '0;
    if (MODE == 0) begin
      sel_valid = !fifo_empty[arb_ptr_reg];
    end else begin
      // Walk from farthest to nearest so the nearest non-empty channel wins
      for (int k = N - 1; k >= 0; k--) begin
        idx = {1'b0, arb_ptr_reg} + (CW+1)'(k);
        if (idx >= (CW+1)'(N)) begin
          idx = idx - (CW+1)'(N);
        end
        if (!fifo_empty[idx[CW-1:0]]) begin
          sel       = idx[CW-1:0];
          sel_valid = 1'b1;
        end
      end
    end
  end

  // Pointer wraps by explicit compare so non-power-of-two N works
  always_comb begin
    if (sel == CW'(N - 1)) begin
      arb_ptr_next = '0;
    end else begin
      arb_ptr_next = sel + CW'(1);
    end
  end

  // Output register and arbiter pointer; holds steady while stalled downstream
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pxl_out     <= '0;
      ch_out      <= '0;
      valid_out   <= 1'b0;
      arb_ptr_reg <= '0;
    end else if (out_free) begin
      if (sel_valid) begin
        pxl_out     <= head[sel];
        ch_out      <= sel;
        valid_out   <= 1'b1;
        arb_ptr_reg <= arb_ptr_next;
      end else begin
        valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_merge_ni.sv
// tb_merge_ni: directed bench for merge_ni. Two instances (ordered and
// round-robin) share the same stimulus and are checked against
// hand-computed expectations.
module tb_merge_ni;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int DP = 16;

  logic            clk;
  logic            reset;
  logic [N-1:0]    valid_in;
  logic [N*DW-1:0] pxl_in;
  logic            ready_out;

  logic [DW-1:0] pxl_out0, pxl_out1;
  logic          valid_out0, valid_out1;
  logic [1:0]    ch_out0, ch_out1;
  logic [N-1:0]  fifo_full0, fifo_full1;
  logic [N-1:0]  overflow0, overflow1;

  int checks = 0;
  int errors = 0;

  merge_ni #(.N(N), .DATA_WIDTH(DW), .DEPTH(DP), .MODE(0)) u_m0 (
    .clk(clk), .reset(reset), .valid_in(valid_in), .pxl_in(pxl_in),
    .ready_out(ready_out), .pxl_out(pxl_out0), .valid_out(valid_out0),
    .ch_out(ch_out0), .fifo_full(fifo_full0), .overflow(overflow0)
  );

  merge_ni #(.N(N), .DATA_WIDTH(DW), .DEPTH(DP), .MODE(1)) u_m1 (
    .clk(clk), .reset(reset), .valid_in(valid_in), .pxl_in(pxl_in),
    .ready_out(ready_out), .pxl_out(pxl_out1), .valid_out(valid_out1),
    .ch_out(ch_out1), .fifo_full(fifo_full1), .overflow(overflow1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  vin;
    logic [7:0]  kin;
    logic        rdy;
    logic        v0;
    logic [31:0] p0;
    logic [1:0]  c0;
    logic        v1;
    logic [31:0] p1;
    logic [1:0]  c1;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pix(input int ch, input logic [31:0] v);
    pxl_in[ch*DW +: DW] = v;
  endtask

  task automatic chk_both_out(input string tag, input logic v, input logic [31:0] p, input logic [1:0] c);
    chk({tag, " m0 valid"}, 32'(valid_out0), 32'(v));
    chk({tag, " m1 valid"}, 32'(valid_out1), 32'(v));
    if (v) begin
      chk({tag, " m0 pxl"}, pxl_out0, p);
      chk({tag, " m1 pxl"}, pxl_out1, p);
      chk({tag, " m0 ch"}, 32'(ch_out0), 32'(c));
      chk({tag, " m1 ch"}, 32'(ch_out1), 32'(c));
    end
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, " m0 valid"}, 32'(valid_out0), 32'd0);
    chk({tag, " m1 valid"}, 32'(valid_out1), 32'd0);
    chk({tag, " m0 ovf"}, 32'(overflow0), 32'd0);
    chk({tag, " m1 ovf"}, 32'(overflow1), 32'd0);
    chk({tag, " m0 full"}, 32'(fifo_full0), 32'd0);
    chk({tag, " m1 full"}, 32'(fifo_full1), 32'd0);
  endtask

  task automatic do_reset();
    valid_in  = '0;
    ready_out = 1'b1;
    reset     = 1'b0;
    #1;
    chk_cleared("reset");
    tick();
    reset = 1'b1;
  endtask

  initial begin
    // Ordered vs round-robin, channel 1 starved then fed late, plus a short hold
    tbl[0]  = '{4'b1101, 8'd0, 1'b1, 1'b0, 32'h00, 2'd0, 1'b0, 32'h00, 2'd0};
    tbl[1]  = '{4'b1101, 8'd1, 1'b1, 1'b1, 32'h00, 2'd0, 1'b1, 32'h00, 2'd0};
    tbl[2]  = '{4'b0000, 8'd0, 1'b1, 1'b0, 32'h00, 2'd0, 1'b1, 32'h20, 2'd2};
    tbl[3]  = '{4'b0000, 8'd0, 1'b1, 1'b0, 32'h00, 2'd0, 1'b1, 32'h30, 2'd3};
    tbl[4]  = '{4'b0000, 8'd0, 1'b1, 1'b0, 32'h00, 2'd0, 1'b1, 32'h01, 2'd0};
    tbl[5]  = '{4'b0010, 8'd0, 1'b1, 1'b0, 32'h00, 2'd0, 1'b1, 32'h21, 2'd2};
    tbl[6]  = '{4'b0000, 8'd0, 1'b1, 1'b1, 32'h10, 2'd1, 1'b1, 32'h31, 2'd3};
    tbl[7]  = '{4'b0000, 8'd0, 1'b1, 1'b1, 32'h20, 2'd2, 1'b1, 32'h10, 2'd1};
    tbl[8]  = '{4'b0000, 8'd0, 1'b1, 1'b1, 32'h30, 2'd3, 1'b0, 32'h10, 2'd1};
    tbl[9]  = '{4'b0000, 8'd0, 1'b1, 1'b1, 32'h01, 2'd0, 1'b0, 32'h10, 2'd1};
    tbl[10] = '{4'b0000, 8'd0, 1'b1, 1'b0, 32'h01, 2'd0, 1'b0, 32'h10, 2'd1};
    tbl[11] = '{4'b0010, 8'd1, 1'b0, 1'b0, 32'h01, 2'd0, 1'b0, 32'h10, 2'd1};
    tbl[12] = '{4'b0000, 8'd0, 1'b0, 1'b1, 32'h11, 2'd1, 1'b1, 32'h11, 2'd1};
    tbl[13] = '{4'b0000, 8'd0, 1'b0, 1'b1, 32'h11, 2'd1, 1'b1, 32'h11, 2'd1};
    tbl[14] = '{4'b0000, 8'd0, 1'b1, 1'b1, 32'h21, 2'd2, 1'b0, 32'h11, 2'd1};
    tbl[15] = '{4'b0000, 8'd0, 1'b1, 1'b1, 32'h31, 2'd3, 1'b0, 32'h11, 2'd1};
    tbl[16] = '{4'b0000, 8'd0, 1'b1, 1'b0, 32'h31, 2'd3, 1'b0, 32'h11, 2'd1};

    // Reset held with random traffic: nothing may leak out
    reset     = 1'b0;
    valid_in  = '0;
    pxl_in    = '0;
    ready_out = 1'b0;
    for (int i = 0; i < 4; i++) begin
      valid_in  = 4'($urandom);
      ready_out = 1'($urandom);
      for (int c = 0; c < N; c++) set_pix(c, $urandom);
      tick();
      chk_cleared($sformatf("in-reset %0d", i));
    end
    valid_in  = '0;
    ready_out = 1'b1;
    reset     = 1'b1;
    tick();
    chk_both_out("idle after release", 1'b0, 32'h0, 2'd0);

    // Table: stall vs work-conserving behaviour
    for (int r = 0; r < 17; r++) begin
      valid_in  = tbl[r].vin;
      ready_out = tbl[r].rdy;
      for (int c = 0; c < N; c++) set_pix(c, 32'(16 * c) + 32'(tbl[r].kin));
      tick();
      $display("row %0d: m0 v=%0b p=%0h c=%0d | m1 v=%0b p=%0h c=%0d",
               r, valid_out0, pxl_out0, ch_out0, valid_out1, pxl_out1, ch_out1);
      chk($sformatf("row%0d m0 valid", r), 32'(valid_out0), 32'(tbl[r].v0));
      chk($sformatf("row%0d m0 pxl", r), pxl_out0, tbl[r].p0);
      chk($sformatf("row%0d m0 ch", r), 32'(ch_out0), 32'(tbl[r].c0));
      chk($sformatf("row%0d m1 valid", r), 32'(valid_out1), 32'(tbl[r].v1));
      chk($sformatf("row%0d m1 pxl", r), pxl_out1, tbl[r].p1);
      chk($sformatf("row%0d m1 ch", r), 32'(ch_out1), 32'(tbl[r].c1));
    end

    // Full-rate ordered stream: 8 pixels on every channel, value 16*ch+k
    do_reset();
    for (int e = 0; e < 34; e++) begin
      valid_in = (e < 8) ? 4'b1111 : 4'b0000;
      for (int c = 0; c < N; c++) set_pix(c, 32'(16 * c + e));
      tick();
      if (e == 0 || e == 33) begin
        chk_both_out($sformatf("stream edge %0d", e), 1'b0, 32'h0, 2'd0);
      end else begin
        chk_both_out($sformatf("stream edge %0d", e), 1'b1,
                     32'(16 * ((e - 1) % 4) + (e - 1) / 4), 2'((e - 1) % 4));
      end
    end

    // Backpressure: 20 cycles of ready_out=0 with every channel writing
    do_reset();
    ready_out = 1'b0;
    for (int j = 0; j < 20; j++) begin
      valid_in = 4'b1111;
      for (int c = 0; c < N; c++) set_pix(c, 32'(256 * c + j));
      tick();
      if (j == 0) chk_both_out("bp edge 0", 1'b0, 32'h0, 2'd0);
      else        chk_both_out($sformatf("bp hold %0d", j), 1'b1, 32'h0, 2'd0);
      chk($sformatf("bp m0 full %0d", j), 32'(fifo_full0),
          (j < 15) ? 32'h0 : (j == 15) ? 32'he : 32'hf);
      chk($sformatf("bp m1 full %0d", j), 32'(fifo_full1),
          (j < 15) ? 32'h0 : (j == 15) ? 32'he : 32'hf);
      chk($sformatf("bp m0 ovf %0d", j), 32'(overflow0),
          (j < 16) ? 32'h0 : (j == 16) ? 32'he : 32'hf);
      chk($sformatf("bp m1 ovf %0d", j), 32'(overflow1),
          (j < 16) ? 32'h0 : (j == 16) ? 32'he : 32'hf);
    end
    valid_in  = '0;
    ready_out = 1'b1;
    for (int m = 1; m <= 64; m++) begin
      tick();
      chk_both_out($sformatf("drain %0d", m), 1'b1, 32'(256 * (m % 4) + m / 4), 2'(m % 4));
    end
    tick();
    chk_both_out("drain end", 1'b0, 32'h0, 2'd0);
    chk("drain m0 full", 32'(fifo_full0), 32'h0);
    chk("drain m0 ovf sticky", 32'(overflow0), 32'hf);
    chk("drain m1 ovf sticky", 32'(overflow1), 32'hf);

    // Wrap: 3*DEPTH pixels per channel, one channel per cycle starting at ch1
    for (int c = 0; c < 3 * DP * N; c++) begin
      valid_in = 4'(1 << ((c + 1) % 4));
      set_pix((c + 1) % 4, 32'hA000_0000 + 32'(c));
      tick();
      if (c == 0) chk_both_out("wrap first", 1'b0, 32'h0, 2'd0);
      else chk_both_out($sformatf("wrap %0d", c), 1'b1, 32'hA000_0000 + 32'(c - 1), 2'(c % 4));
    end
    valid_in = '0;
    tick();
    chk_both_out("wrap last", 1'b1, 32'hA000_0000 + 32'(3 * DP * N - 1), 2'd0);
    chk("wrap m0 ovf sticky", 32'(overflow0), 32'hf);

    // Mid-stream asynchronous reset discards everything buffered
    for (int c = 0; c < 10; c++) begin
      valid_in = 4'(1 << ((c + 1) % 4));
      set_pix((c + 1) % 4, 32'hC000_0000 + 32'(c));
      tick();
    end
    #1;
    reset    = 1'b0;
    valid_in = 4'b1111;
    #1;
    chk_cleared("async mid reset");
    tick();
    chk_cleared("mid reset edge");
    reset    = 1'b1;
    valid_in = '0;
    tick();
    chk_both_out("post reset empty 1", 1'b0, 32'h0, 2'd0);
    tick();
    chk_both_out("post reset empty 2", 1'b0, 32'h0, 2'd0);
    valid_in = 4'b0001;
    set_pix(0, 32'h0000_BEEF);
    tick();
    chk_both_out("post reset write", 1'b0, 32'h0, 2'd0);
    valid_in = '0;
    tick();
    chk_both_out("post reset out", 1'b1, 32'h0000_BEEF, 2'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
